sprite_layer: RTL and testbench
===============================

SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 Parameter SPR_W, 32, sprite width in pixels (power of 2).
REQ-002 Parameter SPR_H, 32, sprite height in pixels.
REQ-003 Parameter IDX_W, 3, palette index width.
REQ-004 Parameter FRAMES, 4, animation frames stored consecutively in ROM.
REQ-005 Parameter FRAME_HOLD, 8, video frames each animation frame is shown.
REQ-006 Parameter TRANSP_IDX, 0, palette index treated as transparent.
REQ-007 Derived ADDR_W = clog2(FRAMES*SPR_W*SPR_H); FS_W = max(1, clog2(FRAMES)).
REQ-008 vga_clk  in  1  pixel clock; all state on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 DrawX  in  10  current pixel column, 0..639.
REQ-011 DrawY  in  10  current pixel row, 0..479.
REQ-012 blank  in  1  1 = active video (drawing allowed).
REQ-013 sprite_x, sprite_y  in  10 each  top-left sprite position.
REQ-014 flip_h  in  1  1 = mirror sprite horizontally.
REQ-015 anim_en  in  1  1 = animation counter runs.
REQ-016 rom_address  out  ADDR_W  address to external synchronous ROM (1-cycle read latency).
REQ-017 rom_q  in  IDX_W  ROM data, valid the cycle after rom_address.
REQ-018 pix_idx  out  IDX_W  palette index of sprite pixel.
REQ-019 pix_hit  out  1  1 = opaque sprite pixel present at this position.
REQ-020 frame_sel  out  FS_W  current animation frame.

Function
REQ-021 frame_start SHALL be a one-cycle strobe when (DrawX,DrawY)=(0,0) and the previous cycle's pair was not (0,0).
REQ-022 On frame_start, sprite_x, sprite_y, flip_h SHALL be latched; mid-frame input changes SHALL have no effect until next frame_start.
REQ-023 in_box SHALL = px<=DrawX<px+SPR_W and py<=DrawY<py+SPR_H, computed in 11 bits (no wrap for sprites past the right/bottom edge).
REQ-024 col = DrawX-px, or SPR_W-1-(DrawX-px) when latched flip_h=1; row = DrawY-py.
REQ-025 Stage 1: rom_address SHALL be registered as frame_sel*SPR_W*SPR_H + row*SPR_W + col when in_box, else 0; in_box&blank registered alongside.
REQ-026 Stage 2: rom_q valid; stage-1 flag delayed one more cycle to align.
REQ-027 Stage 3: pix_hit <= flag & (rom_q != TRANSP_IDX); pix_idx <= rom_q when hit, else 0.
REQ-028 Latency DrawX/DrawY -> pix_idx/pix_hit SHALL be exactly 3 cycles; throughput one pixel per cycle, no stalls.
REQ-029 Hold counter SHALL increment on frame_start when anim_en=1; at FRAME_HOLD-1 it SHALL clear and frame_sel SHALL advance, wrapping FRAMES-1 -> 0.
REQ-030 anim_en=0 SHALL freeze hold counter and frame_sel (no clear).
REQ-031 frame_sel SHALL change only on frame_start cycles (no mid-frame tearing).
REQ-032 FRAMES=1 SHALL keep frame_sel at 0 permanently.

Reset
REQ-033 While reset=1, rom_address, pix_idx, pix_hit, frame_sel, hold counter, latched position/flip and pipeline flags SHALL be 0, taking effect immediately (asynchronously).
REQ-034 After reset deasserts mid-frame, pix_hit SHALL stay 0 until latched position is used, i.e. sprite appears at (0,0) until next frame_start.

Verification
REQ-035 Reset; sprite_x=100, sprite_y=50, pass (0,0); at DrawX=100,DrawY=50 -> rom_address=0 next cycle; ROM q=5 -> pix_idx=5, pix_hit=1 exactly 3 cycles after; DrawX=132 -> pix_hit=0.
REQ-036 flip_h=1 latched; DrawX=100, DrawY=51 -> rom_address=63 (1*32+31); DrawX=131 -> rom_address=32.
REQ-037 In box with rom_q=0 -> pix_hit=0, pix_idx=0; in box with rom_q=6, blank=0 -> pix_hit=0.
REQ-038 anim_en=1 for 8 frame_starts -> frame_sel=1; after 32 -> frame_sel=0; with frame_sel=2, pixel (100,50) -> rom_address=2048; anim_en=0 for 10 frames -> frame_sel unchanged.
REQ-039 Change sprite_x to 200 at DrawY=60 -> rows 60..81 still hit at DrawX=100..131; after next frame_start hits move to 200..231.
REQ-040 Assert reset mid-frame with frame_sel=3, pix_hit=1 -> all outputs 0 in same cycle; release -> frame_sel counts from 0.

Source files
------------

// File: rtl/sprite_layer.sv
// Animated sprite overlay: box test and ROM addressing in stage 1, ROM read in stage 2,
// transparency keying in stage 3. Position, flip and animation frame change only at frame start.
module sprite_layer #(
    parameter int unsigned SPR_W      = 32,
    parameter int unsigned SPR_H      = 32,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned FRAMES     = 4,
    parameter int unsigned FRAME_HOLD = 8,
    parameter int unsigned TRANSP_IDX = 0,
    localparam int unsigned ADDR_W    = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int unsigned FS_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_h,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_hit,
    output logic [FS_W-1:0]   frame_sel
);

    localparam int unsigned COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    logic              prev_zero;
    logic              at_zero_c;
    logic              frame_start_c;
    logic [9:0]        px_q;
    logic [9:0]        py_q;
    logic              flip_q;
    logic [HOLD_W-1:0] hold;
    logic              flag1;
    logic              flag2;
    logic              in_box_c;
    logic [COL_W-1:0]  col_c;
    logic [ROW_W-1:0]  row_c;
    logic [ADDR_W-1:0] addr_c;
    logic              hit_c;

    assign at_zero_c     = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_start_c = at_zero_c && !prev_zero;

    // Sprite placement is sampled once per frame so a moving sprite never tears.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            prev_zero <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            flip_q    <= 1'b0;
        end else begin
            prev_zero <= at_zero_c;
            if (frame_start_c) begin
                px_q   <= sprite_x;
                py_q   <= sprite_y;
                flip_q <= flip_h;
            end
        end
    end

    // Animation: each frame is held for FRAME_HOLD video frames.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            frame_sel <= '0;
        end else if (frame_start_c && anim_en) begin
            if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
                hold <= '0;
                if (FRAMES > 1) begin
                    frame_sel <= (frame_sel == FS_W'(FRAMES - 1)) ? '0 : frame_sel + FS_W'(1);
                end
            end else begin
                hold <= hold + HOLD_W'(1);
            end
        end
    end

    // Box test in 11 bits so a sprite near the right/bottom edge cannot wrap.
    always_comb begin
        in_box_c = (DrawX >= px_q) && (11'(DrawX) < 11'(px_q) + 11'(SPR_W)) &&
                   (DrawY >= py_q) && (11'(DrawY) < 11'(py_q) + 11'(SPR_H));
        col_c    = COL_W'(DrawX - px_q);
        if (flip_q) begin
            col_c = COL_W'(SPR_W - 1) - col_c;
        end
        row_c    = ROW_W'(DrawY - py_q);
        addr_c   = ADDR_W'(frame_sel) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(row_c) * ADDR_W'(SPR_W)
                 + ADDR_W'(col_c);
    end

    assign hit_c = flag2 && (rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
            flag1       <= 1'b0;
            flag2       <= 1'b0;
            pix_hit     <= 1'b0;
            pix_idx     <= '0;
        end else begin
            rom_address <= in_box_c ? addr_c : '0;
            flag1       <= in_box_c && blank;
            flag2       <= flag1;
            pix_hit     <= hit_c;
            pix_idx     <= hit_c ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed and randomized checks of sprite_layer against a per-pixel reference model.
module tb_sprite_layer;

    localparam int SPR_W = 32;
    localparam int SPR_H = 32;
    localparam int FRAMES = 4;
    localparam int FRAME_HOLD = 8;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
    logic        blank, flip_h, anim_en;
    logic [11:0] rom_address;
    logic [2:0]  rom_q;
    logic [2:0]  pix_idx;
    logic        pix_hit;
    logic [1:0]  frame_sel;

    logic [2:0]  rom [0:4095];

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_px, m_py, anim_ticks;
    bit m_flip, m_prev_zero;
    int h_hit[3];
    int h_idx[3];

    sprite_layer dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h), .anim_en(anim_en),
        .rom_address(rom_address), .rom_q(rom_q), .pix_idx(pix_idx), .pix_hit(pix_hit),
        .frame_sel(frame_sel)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom[rom_address];

    function automatic int model_fsel();
        return (anim_ticks / FRAME_HOLD) % FRAMES;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        logic [31:0] expv;
        expv = 32'(exp);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_px = 0; m_py = 0; m_flip = 0; anim_ticks = 0; m_prev_zero = 0;
        for (int i = 0; i < 3; i++) begin
            h_hit[i] = 0;
            h_idx[i] = 0;
        end
    endtask

    // One pixel per clock; rom_address checks this pixel, pix_* the pixel two steps back.
    task automatic step(input int x, input int y, input bit b);
        int fs, addr, hit, idx;
        bit inb;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        fs  = model_fsel();
        inb = (x >= m_px) && (x < m_px + SPR_W) && (y >= m_py) && (y < m_py + SPR_H);
        addr = 0;
        if (inb)
            addr = fs * SPR_W * SPR_H + (y - m_py) * SPR_W
                 + (m_flip ? (SPR_W - 1 - (x - m_px)) : (x - m_px));
        hit = (inb && b && rom[addr] != 3'd0) ? 1 : 0;
        idx = hit ? int'(rom[addr]) : 0;
        h_hit[2] = h_hit[1]; h_hit[1] = h_hit[0]; h_hit[0] = hit;
        h_idx[2] = h_idx[1]; h_idx[1] = h_idx[0]; h_idx[0] = idx;
        if (x == 0 && y == 0 && !m_prev_zero) begin
            m_px = int'(sprite_x);
            m_py = int'(sprite_y);
            m_flip = flip_h;
            if (anim_en) anim_ticks++;
        end
        m_prev_zero = (x == 0 && y == 0);
        @(posedge vga_clk);
        #1;
        chk("rom_address", 32'(rom_address), addr);
        chk("pix_hit", 32'(pix_hit), h_hit[2]);
        chk("pix_idx", 32'(pix_idx), h_idx[2]);
        chk("frame_sel", 32'(frame_sel), model_fsel());
    endtask

    task automatic new_frame();
        step(639, 479, 0);
        step(0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(rom_address), 0);
        chk({tag, "_hit"}, 32'(pix_hit), 0);
        chk({tag, "_idx"}, 32'(pix_idx), 0);
        chk({tag, "_fsel"}, 32'(frame_sel), 0);
    endtask

    initial begin
        int x, y, guard;
        for (int i = 0; i < 4096; i++) rom[i] = 3'($urandom);
        rom[0] = 3'd5;
        rom[1] = 3'd0;
        rom[2] = 3'd6;
        rom[3072] = 3'd7;
        reset = 1'b0;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        sprite_x = '0; sprite_y = '0; flip_h = 1'b0; anim_en = 1'b0;
        model_reset();

        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge vga_clk);
        #2 reset = 1'b0;

        // Basic placement, transparency and blanking
        sprite_x = 10'd100; sprite_y = 10'd50;
        new_frame();
        step(100, 50, 1);
        chk("first_addr", 32'(rom_address), 0);
        step(101, 50, 1);
        step(102, 50, 0);
        chk("first_hit", 32'(pix_hit), 1);
        chk("first_idx", 32'(pix_idx), 5);
        step(103, 50, 1);
        chk("transp_hit", 32'(pix_hit), 0);
        step(132, 50, 1);
        chk("blank_hit", 32'(pix_hit), 0);
        step(133, 50, 1);
        step(134, 50, 1);
        chk("right_edge_hit", 32'(pix_hit), 0);

        // Horizontal mirror
        flip_h = 1'b1;
        new_frame();
        step(100, 51, 1);
        chk("flip_addr_left", 32'(rom_address), 63);
        step(131, 51, 1);
        chk("flip_addr_right", 32'(rom_address), 32);
        flip_h = 1'b0;

        // Animation advance, wrap and freeze
        anim_en = 1'b1;
        repeat (8) new_frame();
        chk("fsel_after_8", 32'(frame_sel), 1);
        repeat (24) new_frame();
        chk("fsel_after_32", 32'(frame_sel), 0);
        repeat (16) new_frame();
        chk("fsel_after_48", 32'(frame_sel), 2);
        step(100, 50, 1);
        chk("addr_frame2", 32'(rom_address), 2048);
        anim_en = 1'b0;
        repeat (10) new_frame();
        chk("fsel_frozen", 32'(frame_sel), 2);

        // Mid-frame move takes effect only at the next frame start
        for (y = 60; y <= 81; y++) begin
            if (y == 60) sprite_x = 10'd200;
            for (x = 98; x <= 133; x++) step(x, y, 1);
        end
        new_frame();
        for (x = 198; x <= 233; x++) step(x, 60, 1);

        // Randomized frames with mid-frame input noise
        for (int f = 0; f < 16; f++) begin
            sprite_x = 10'($urandom_range(0, 639));
            sprite_y = 10'($urandom_range(0, 479));
            flip_h   = 1'($urandom);
            anim_en  = 1'($urandom);
            new_frame();
            sprite_x = 10'($urandom_range(0, 639));
            flip_h   = 1'($urandom);
            for (int p = 0; p < 60; p++) begin
                x = m_px + int'($urandom_range(0, 40)) - 4;
                y = m_py + int'($urandom_range(0, 40)) - 4;
                if (x < 1) x = 1;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                step(x, y, ($urandom_range(0, 4) != 0));
            end
        end

        // Asynchronous reset while a pixel is being shown
        sprite_x = 10'd100; sprite_y = 10'd50; flip_h = 1'b0; anim_en = 1'b1;
        new_frame();
        guard = 0;
        while (model_fsel() != 3 && guard < 40) begin
            new_frame();
            guard++;
        end
        anim_en = 1'b0;
        new_frame();
        chk("pre_reset_fsel", 32'(frame_sel), 3);
        step(100, 50, 1);
        step(300, 300, 1);
        step(301, 300, 1);
        chk("pre_reset_hit", 32'(pix_hit), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        model_reset();
        #1 reset = 1'b0;
        step(5, 5, 1);
        step(6, 5, 1);
        step(7, 5, 1);
        anim_en = 1'b1;
        new_frame();
        chk("post_reset_fsel0", 32'(frame_sel), 0);
        repeat (7) new_frame();
        chk("post_reset_fsel1", 32'(frame_sel), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
